uart_aes_link: RTL and testbench
================================

Name: uart_aes_link

Overview:
Host-link framer between the UART byte interface and the AES core used for CPA capture. It consumes received bytes and assembles command frames: load a 128-bit key, or load a plaintext and encrypt. For an encrypt, it starts the AES core, drives the scope trigger while the core runs, and returns the ciphertext as 16 bytes via the UART transmit handshake.

Parameters:
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between bytes of one frame before the frame is aborted.
TIMEOUT_W, 20, width of the inter-byte timeout counter; must satisfy 2**TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  reset, synchronous, active-low (block resets when rst==0 at posedge clk).
rx_byte  in  8  byte from UART receiver.
received  in  1  one-cycle strobe; rx_byte valid.
recv_error  in  1  one-cycle strobe; UART framing error.
tx_byte  out  8  byte to UART transmitter.
transmit  out  1  transmit request level to UART.
is_transmitting  in  1  UART transmitter busy.
aes_key  out  128  key register.
aes_pt  out  128  plaintext register.
aes_start  out  1  one-cycle start pulse to AES core.
aes_done  in  1  one-cycle completion strobe from AES core.
aes_ct  in  128  ciphertext; valid when aes_done==1.
trig  out  1  scope trigger.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE; tx_byte=0, transmit=0, aes_key=0, aes_pt=0, aes_start=0, trig=0, busy=0; byte_cnt=0; timeout counter=0. Reset mid-frame or mid-transmit abandons the operation immediately.
- Frame format: command byte, then 16 data bytes. The first data byte lands in bits [127:120] and the last in [7:0]. Responses are sent MSB-byte first.
- Commands: 0x01 LOAD_KEY, 0x02 ENCRYPT. Any other command is answered with a single NAK byte 0xEE.
- States:
  - IDLE: on received, latch the command.
    - Valid command: byte_cnt=0, go to RX_DATA.
    - Invalid command: tx_buf=0xEE, tx_len=1, go to TX_LOAD.
  - RX_DATA: on received, shift the byte into the target register (aes_key or aes_pt, selected by command) and increment byte_cnt (4-bit). Clear the timeout counter on every received byte.
    - When the 16th byte arrives (byte_cnt==15 at receipt, counter wraps to 0):
      - LOAD_KEY: send ACK 0xA5 (tx_len=1) via TX_LOAD.
      - ENCRYPT: go to START.
    - recv_error, or timeout counter reaching TIMEOUT_CYCLES: discard the frame, go to IDLE. The target register keeps whatever partial contents were shifted in.
  - START: aes_start=1 for exactly one cycle; trig=1 from this cycle; go to WAIT_AES.
  - WAIT_AES: trig held high. On aes_done: trig=0 on the next edge, latch aes_ct into tx_buf, tx_len=16, go to TX_LOAD. No timeout in this state.
  - TX_LOAD: tx_byte = tx_buf[127:120] (or the ACK/NAK byte); transmit=1; go to TX_WAIT_BUSY.
  - TX_WAIT_BUSY: when is_transmitting==1, transmit=0 and go to TX_WAIT_IDLE. transmit must drop; the UART holds busy until the request is released.
  - TX_WAIT_IDLE: when is_transmitting==0, decrement the remaining count and shift tx_buf left 8 bits. Go to TX_LOAD if bytes remain, else IDLE.
- received or recv_error in any state other than IDLE/RX_DATA: ignored; the byte is dropped. The host must wait for the response.
- received and timeout expiry in the same cycle: the byte wins; the counter clears.
- aes_done outside WAIT_AES: ignored.
- Latency: aes_start asserts 2 cycles after the received strobe of the final data byte. The first response byte has transmit=1 1 cycle after entering TX_LOAD.

Decomposition:
- Shared package uart_link_pkg: command/response constants (CMD_LOAD_KEY=8'h01, CMD_ENCRYPT=8'h02, RSP_ACK=8'hA5, RSP_NAK=8'hEE) and the state enumeration localparams.
- One natural sub-module: uart_tx_seq. It owns tx_buf, tx_len and the TX_LOAD/TX_WAIT_BUSY/TX_WAIT_IDLE handshake. Interface: load strobe, 128-bit buffer, length, done pulse.

Test Plan:
- Send 0x01 then bytes 0x00..0x0F -> aes_key==128'h000102030405060708090A0B0C0D0E0F; one tx byte 0xA5; busy returns to 0.
- Load the key, then send 0x02 + 16 bytes 0x11; model the AES with aes_done 50 cycles after aes_start and aes_ct=128'hDEADBEEF...F00D -> aes_start is exactly one pulse, trig high for 51 cycles, 16 tx bytes DE,AD,BE,EF,…,F0,0D in order.
- Send command 0x7E -> exactly one tx byte 0xEE; aes_start never asserts.
- Send 0x02 + 5 bytes, then idle for TIMEOUT_CYCLES+1 (override to 100) -> return to IDLE with no tx and no aes_start; a following valid frame completes normally.
- During ciphertext transmit, hold is_transmitting high for 3 extra cycles per byte and inject received bytes -> transmit drops within 1 cycle of is_transmitting rising; no byte is sent twice; injected bytes are ignored.
- Pull rst low in WAIT_AES and again mid-transmit -> the next cycle has all outputs at their reset values and state IDLE; a late aes_done is ignored.

Source files
------------

// File: rtl/uart_link_pkg.sv
// Shared constants and state encodings for the UART/AES host link.
// Holds command/response bytes and the link and transmit FSM states.
package uart_link_pkg;

    localparam logic [7:0] CMD_LOAD_KEY = 8'h01;
    localparam logic [7:0] CMD_ENCRYPT  = 8'h02;
    localparam logic [7:0] RSP_ACK      = 8'hA5;
    localparam logic [7:0] RSP_NAK      = 8'hEE;

    localparam int FRAME_BYTES = 16;

    // Link-level states; the three transmit states live in uart_tx_seq.
    typedef enum logic [2:0] {
        L_IDLE,
        L_RX_DATA,
        L_START,
        L_WAIT_AES,
        L_TX
    } link_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_LOAD,
        T_WAIT_BUSY,
        T_WAIT_IDLE
    } tx_state_t;

    function automatic logic is_valid_cmd(input logic [7:0] c);
        return (c == CMD_LOAD_KEY) || (c == CMD_ENCRYPT);
    endfunction

endpackage

// File: rtl/uart_aes_link_if.sv
// Bundle of UART byte handshake and AES core signals for uart_aes_link.
// master: the link framer; slave: the UART + AES core side.
interface uart_aes_link_if;

    logic [7:0]   rx_byte;
    logic         received;
    logic         recv_error;
    logic [7:0]   tx_byte;
    logic         transmit;
    logic         is_transmitting;
    logic [127:0] aes_key;
    logic [127:0] aes_pt;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_ct;
    logic         trig;
    logic         busy;

    modport master (
        input  rx_byte, received, recv_error, is_transmitting,
        input  aes_done, aes_ct,
        output tx_byte, transmit, aes_key, aes_pt,
        output aes_start, trig, busy
    );

    modport slave (
        output rx_byte, received, recv_error, is_transmitting,
        output aes_done, aes_ct,
        input  tx_byte, transmit, aes_key, aes_pt,
        input  aes_start, trig, busy
    );

endinterface

// File: rtl/uart_tx_seq.sv
// Response transmitter: sends tx_len bytes of a 128-bit buffer, MSB first,
// over a transmit/is_transmitting level handshake.
// Ports: clk, rst (sync, active-low), load_i/buf_i/len_i (start a response),
// is_transmitting_i (UART busy), tx_byte_o/transmit_o (to UART),
// done_o (one-cycle pulse as the last byte completes).
module uart_tx_seq
    import uart_link_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [127:0] buf_i,
    input  logic [4:0]   len_i,
    input  logic         is_transmitting_i,
    output logic [7:0]   tx_byte_o,
    output logic         transmit_o,
    output logic         done_o
);

    tx_state_t    state_q, state_d;
    logic [127:0] buf_q, buf_d;
    logic [4:0]   len_q, len_d;
    logic [7:0]   byte_q, byte_d;
    logic         xmit_q, xmit_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= T_IDLE;
            buf_q   <= '0;
            len_q   <= '0;
            byte_q  <= '0;
            xmit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
            xmit_q  <= xmit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        byte_d  = byte_q;
        xmit_d  = xmit_q;
        done_o  = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                if (load_i) begin
                    buf_d   = buf_i;
                    len_d   = len_i;
                    state_d = T_LOAD;
                end
            end
            T_LOAD: begin
                byte_d  = buf_q[127:120];
                xmit_d  = 1'b1;
                state_d = T_WAIT_BUSY;
            end
            T_WAIT_BUSY: begin
                // Release the request as soon as the UART accepts it,
                // otherwise it would resend the same byte.
                if (is_transmitting_i) begin
                    xmit_d  = 1'b0;
                    state_d = T_WAIT_IDLE;
                end
            end
            T_WAIT_IDLE: begin
                if (!is_transmitting_i) begin
                    len_d = len_q - 5'd1;
                    buf_d = {buf_q[119:0], 8'h00};
                    if (len_q == 5'd1) begin
                        done_o  = 1'b1;
                        state_d = T_IDLE;
                    end else begin
                        state_d = T_LOAD;
                    end
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    assign tx_byte_o  = byte_q;
    assign transmit_o = xmit_q;

endmodule

// File: rtl/uart_aes_link.sv
// Host-link framer: assembles key/plaintext frames from UART bytes, runs the
// AES core with a scope trigger, and returns ACK/NAK or the ciphertext.
// Ports: clk, rst (sync, active-low), bus (uart_aes_link_if.master: UART rx/tx
// handshake, AES key/pt/start/done/ct, trig, busy).
module uart_aes_link #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic            clk,
    input  logic            rst,
    uart_aes_link_if.master bus
);

    import uart_link_pkg::*;

    localparam logic [TIMEOUT_W-1:0] TO_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

    link_state_t          state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         pt_q, pt_d;
    logic                 start_q, start_d;
    logic                 trig_q, trig_d;

    logic                 ld;
    logic [127:0]         ld_buf;
    logic [4:0]           ld_len;
    logic                 seq_done;
    logic [7:0]           seq_byte;
    logic                 seq_xmit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= L_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            start_q <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            start_q <= start_d;
            trig_q  <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        key_d   = key_q;
        pt_d    = pt_q;
        start_d = 1'b0;
        trig_d  = trig_q;
        ld      = 1'b0;
        ld_buf  = '0;
        ld_len  = '0;
        unique case (state_q)
            L_IDLE: begin
                if (bus.received) begin
                    cmd_d = bus.rx_byte;
                    cnt_d = '0;
                    to_d  = '0;
                    if (is_valid_cmd(bus.rx_byte)) begin
                        state_d = L_RX_DATA;
                    end else begin
                        ld      = 1'b1;
                        ld_buf  = {RSP_NAK, 120'h0};
                        ld_len  = 5'd1;
                        state_d = L_TX;
                    end
                end
            end
            L_RX_DATA: begin
                if (bus.recv_error) begin
                    to_d    = '0;
                    state_d = L_IDLE;
                end else if (bus.received) begin
                    // A byte always beats a timeout expiring in this cycle.
                    to_d  = '0;
                    cnt_d = cnt_q + 4'd1;
                    if (cmd_q == CMD_LOAD_KEY) begin
                        key_d = {key_q[119:0], bus.rx_byte};
                    end else begin
                        pt_d = {pt_q[119:0], bus.rx_byte};
                    end
                    if (cnt_q == 4'd15) begin
                        if (cmd_q == CMD_LOAD_KEY) begin
                            ld      = 1'b1;
                            ld_buf  = {RSP_ACK, 120'h0};
                            ld_len  = 5'd1;
                            state_d = L_TX;
                        end else begin
                            state_d = L_START;
                        end
                    end
                end else if (to_q == TO_MAX) begin
                    to_d    = '0;
                    state_d = L_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            L_START: begin
                start_d = 1'b1;
                trig_d  = 1'b1;
                state_d = L_WAIT_AES;
            end
            L_WAIT_AES: begin
                if (bus.aes_done) begin
                    trig_d  = 1'b0;
                    ld      = 1'b1;
                    ld_buf  = bus.aes_ct;
                    ld_len  = 5'(FRAME_BYTES);
                    state_d = L_TX;
                end
            end
            L_TX: begin
                if (seq_done) state_d = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
    end

    uart_tx_seq u_tx_seq (
        .clk               (clk),
        .rst               (rst),
        .load_i            (ld),
        .buf_i             (ld_buf),
        .len_i             (ld_len),
        .is_transmitting_i (bus.is_transmitting),
        .tx_byte_o         (seq_byte),
        .transmit_o        (seq_xmit),
        .done_o            (seq_done)
    );

    assign bus.tx_byte   = seq_byte;
    assign bus.transmit  = seq_xmit;
    assign bus.aes_key   = key_q;
    assign bus.aes_pt    = pt_q;
    assign bus.aes_start = start_q;
    assign bus.trig      = trig_q;
    assign bus.busy      = (state_q != L_IDLE);

endmodule

// File: tb/tb_uart_aes_link.sv
// Directed self-checking bench for uart_aes_link with a UART responder model.
// Drives frames, models the AES core by hand, checks outputs at negedges.
module tb_uart_aes_link;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_aes_link_if bus ();

    uart_aes_link #(
        .TIMEOUT_CYCLES (100),
        .TIMEOUT_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] txq[$];
    int hold_extra = 0;
    int lag_max    = 0;
    int start_cnt  = 0;

    always @(posedge clk) if (bus.aes_start === 1'b1) start_cnt++;

    // UART transmitter model: accepts a request, raises busy, waits for the
    // request to drop, then holds busy for hold_extra more cycles.
    initial begin
        int lag;
        bus.is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.transmit === 1'b1) begin
                txq.push_back(bus.tx_byte);
                bus.is_transmitting = 1'b1;
                lag = 0;
                @(negedge clk);
                while (bus.transmit === 1'b1 && lag < 20) begin
                    lag++;
                    @(negedge clk);
                end
                if (lag > lag_max) lag_max = lag;
                repeat (hold_extra) @(negedge clk);
                bus.is_transmitting = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.received = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && bus.busy !== 1'b0; i++) @(negedge clk);
        chk(tag, bus.busy, 1'b0);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 20 && bus.aes_start !== 1'b1; i++) @(negedge clk);
        chk(tag, bus.aes_start, 1'b1);
    endtask

    task automatic pulse_done(input logic [127:0] ct);
        bus.aes_ct   = ct;
        bus.aes_done = 1'b1;
        @(negedge clk);
        bus.aes_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_trig"}, bus.trig, 1'b0);
        chk({tag, "_transmit"}, bus.transmit, 1'b0);
        chk({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
        chk({tag, "_start"}, bus.aes_start, 1'b0);
        chk({tag, "_key"}, bus.aes_key, 128'h0);
        chk({tag, "_pt"}, bus.aes_pt, 128'h0);
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] got;
        int trig_cnt;
        int s0;
        int n;

        rst            = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.received   = 1'b0;
        bus.recv_error = 1'b0;
        bus.aes_done   = 1'b0;
        bus.aes_ct     = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Key load 00..0F
        send_byte(8'h01);
        chk("key_busy", bus.busy, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        wait_idle("key_idle");
        chk("key_val", bus.aes_key, 128'h000102030405060708090A0B0C0D0E0F);
        chk("key_txn", txq.size(), 1);
        chk("key_ack", txq[0], 8'hA5);
        txq.delete();

        // Encrypt with slow UART and injected bytes
        hold_extra = 3;
        ct = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        send_byte(8'h02);
        for (int i = 0; i < 15; i++) send_byte(8'h11);
        send_byte(8'h11);
        chk("enc_start_lat1", bus.aes_start, 1'b0);
        @(negedge clk);
        chk("enc_start_lat2", bus.aes_start, 1'b1);
        chk("enc_trig_on", bus.trig, 1'b1);
        chk("enc_pt", bus.aes_pt, {16{8'h11}});
        trig_cnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.trig === 1'b1) trig_cnt++;
        end
        pulse_done(ct);
        chk("enc_trig_off", bus.trig, 1'b0);
        chk("enc_trig_len", trig_cnt, 51);
        for (int i = 0; i < 500 && txq.size() < 3; i++) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h7E);
        @(negedge clk);
        bus.recv_error = 1'b1;
        @(negedge clk);
        bus.recv_error = 1'b0;
        wait_idle("enc_idle");
        repeat (40) @(negedge clk);
        chk("enc_txn", txq.size(), 16);
        got = '0;
        for (int i = 0; i < 16 && i < txq.size(); i++) got = {got[119:0], txq[i]};
        chk("enc_ct_bytes", got, ct);
        chk("enc_tx_lag", lag_max, 0);
        chk("enc_start_cnt", start_cnt, 1);
        chk("enc_key_kept", bus.aes_key, 128'h000102030405060708090A0B0C0D0E0F);
        txq.delete();
        hold_extra = 0;

        // Invalid command -> NAK
        s0 = start_cnt;
        send_byte(8'h7E);
        wait_idle("nak_idle");
        repeat (20) @(negedge clk);
        chk("nak_txn", txq.size(), 1);
        chk("nak_byte", txq[0], 8'hEE);
        chk("nak_nostart", start_cnt, s0);
        txq.delete();

        // Timeout after partial frame
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i));
        repeat (95) @(negedge clk);
        chk("to_still_busy", bus.busy, 1'b1);
        repeat (15) @(negedge clk);
        chk("to_idle", bus.busy, 1'b0);
        chk("to_notx", txq.size(), 0);
        chk("to_nostart", start_cnt, s0);
        chk("to_pt_partial", bus.aes_pt, 128'h1111_1111_1111_1111_1111_1121_2223_2425);
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) send_byte(8'hF0 + 8'(i));
        wait_idle("to_key_idle");
        chk("to_key_val", bus.aes_key, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        chk("to_key_ack", txq.size() == 1 ? txq[0] : 8'h00, 8'hA5);
        txq.delete();

        // Reset during WAIT_AES, then a late aes_done
        send_byte(8'h02);
        for (int i = 0; i < 16; i++) send_byte(8'h33);
        wait_start("rw_start");
        repeat (10) @(negedge clk);
        chk("rw_trig_pre", bus.trig, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rw");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse_done(ct);
        repeat (20) @(negedge clk);
        chk("rw_late_busy", bus.busy, 1'b0);
        chk("rw_late_trig", bus.trig, 1'b0);
        chk("rw_late_notx", txq.size(), 0);

        // Reset mid-transmit
        send_byte(8'h02);
        for (int i = 0; i < 16; i++) send_byte(8'h44);
        wait_start("rt_start");
        repeat (5) @(negedge clk);
        pulse_done(ct);
        for (int i = 0; i < 500 && txq.size() < 4; i++) @(negedge clk);
        chk("rt_some_tx", txq.size() >= 4, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rt");
        rst = 1'b1;
        n = txq.size();
        repeat (50) @(negedge clk);
        chk("rt_no_more_tx", txq.size(), n);
        chk("rt_idle", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
